// File: rtl/des_round_engine_if.sv
// Handshake and f-function bus between the DES round engine and its neighbours.
// The engine side uses the slave modport; the driver of blocks, the f-function
// path and the output consumer together form the master side.
interface des_round_engine_if;
    logic         in_valid;
    logic         in_ready;
    logic [64:1]  data_in;
    logic         decrypt;
    logic [32:1]  f_r_out;
    logic [4:1]   round_idx;
    logic [32:1]  f_in;
    logic         out_valid;
    logic         out_ready;
    logic [64:1]  data_out;
    logic         busy;

    modport master (
        output in_valid, data_in, decrypt, f_in, out_ready,
        input  in_ready, f_r_out, round_idx, out_valid, data_out, busy
    );

    modport slave (
        input  in_valid, data_in, decrypt, f_in, out_ready,
        output in_ready, f_r_out, round_idx, out_valid, data_out, busy
    );
endinterface

// File: rtl/des_round_engine.sv
// Iterative DES Feistel round controller. Holds the L/R halves, exposes R to the
// external f-function, folds the returned f value into L and swaps halves once
// per cycle. After ROUNDS iterations it presents R16||L16 (final swap omitted)
// and holds it until the downstream stage accepts it.
module des_round_engine #(
    parameter int ROUNDS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    des_round_engine_if.slave     bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [5:1] LP_ROUNDS    = 5'(ROUNDS);
    // Only the low four bits of ROUNDS+1 matter: the subkey index port is
    // four bits wide, so index 16 is presented as 0 modulo 16.
    localparam logic [4:1] LP_ROUNDS_P1 = 4'(ROUNDS + 1);

    state_t       r_state;
    state_t       w_next_state;
    logic [32:1]  r_l;
    logic [32:1]  r_r;
    logic [5:1]   r_cnt;
    logic         r_dec;
    logic [64:1]  r_data_out;
    logic         r_out_valid;

    logic         w_last_round;
    logic [32:1]  w_new_r;
    logic [4:1]   w_round_idx;

    assign w_last_round = (r_state == S_RUN) && (r_cnt == LP_ROUNDS);
    assign w_new_r      = r_l ^ bus.f_in;
    assign w_round_idx  = r_dec ? (LP_ROUNDS_P1 - r_cnt[4:1]) : r_cnt[4:1];

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.f_r_out   = r_r;
    assign bus.round_idx = (r_state == S_RUN) ? w_round_idx : 4'd0;
    assign bus.out_valid = r_out_valid;
    assign bus.data_out  = r_data_out;

    // State register; reset aborts any block in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: accept in IDLE, iterate in RUN, wait for the consumer in DONE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (bus.in_valid) w_next_state = S_RUN;
            S_RUN:  if (r_cnt == LP_ROUNDS) w_next_state = S_DONE;
            S_DONE: if (r_out_valid && bus.out_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath: load halves, run one Feistel round per cycle, capture and hold the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_l         <= '0;
            r_r         <= '0;
            r_cnt       <= '0;
            r_dec       <= 1'b0;
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_l   <= bus.data_in[64:33];
                        r_r   <= bus.data_in[32:1];
                        r_dec <= bus.decrypt;
                        r_cnt <= 5'd1;
                    end
                end
                S_RUN: begin
                    r_l <= r_r;
                    r_r <= w_new_r;
                    if (w_last_round) begin
                        r_data_out  <= {w_new_r, r_r};
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                S_DONE: begin
                    if (r_out_valid && bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_cnt       <= '0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_cnt       <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/des_round_engine.md
Name: des_round_engine

Overview:
- Iterative DES Feistel round controller; sits directly downstream of the P permutation.
- Holds the L/R half-block registers and feeds R to the external f-function path (expansion -> key XOR -> S-boxes -> P).
- Each cycle it consumes the P output, XORs it into L and swaps halves.
- After ROUNDS iterations it presents the pre-output block R16||L16 to the final-permutation stage; IP and FP stay outside this block.

Parameters:
- ROUNDS, 16: number of Feistel iterations per block; legal range 1..16.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  data_in/decrypt valid.
- in_ready  output  1  engine can accept a block.
- data_in  input  [64:1]  post-IP block; [64:33]=L0, [32:1]=R0.
- decrypt  input  1  sampled with data_in; 1 = reverse subkey order.
- f_r_out  output  [32:1]  current R register, to expansion stage.
- round_idx  output  [4:1]  subkey index for key schedule; 0 when not running.
- f_in  input  [32:1]  f-function result from P stage; combinational from f_r_out/round_idx, same cycle.
- out_valid  output  1  data_out valid.
- out_ready  input  1  downstream accepts data_out.
- data_out  output  [64:1]  pre-output block; [64:33]=R16, [32:1]=L16.
- busy  output  1  high in RUN or DONE.

Behaviour:
- States: IDLE, RUN, DONE; 2-bit state register plus 5-bit round counter cnt.
- Reset (async, any state):
  - State=IDLE; L, R, cnt, dec_q, data_out = 0.
  - out_valid=0, busy=0, round_idx=0, f_r_out=0, in_ready=1.
  - A block in flight is discarded; no output is produced for it.
- in_ready = (state==IDLE); combinational from state only.
- IDLE:
  - On in_valid & in_ready: L<=data_in[64:33], R<=data_in[32:1], dec_q<=decrypt, cnt<=1, state<=RUN.
  - in_valid low: hold.
- RUN, each cycle:
  - L<=R; R<=L ^ f_in; cnt<=cnt+1.
  - round_idx = dec_q ? (ROUNDS+1-cnt) : cnt, i.e. 1..16 encrypt, 16..1 decrypt.
  - When cnt==ROUNDS: perform the final round; data_out<={L ^ f_in, R} (the final swap omitted, so the result is R16||L16); out_valid<=1; state<=DONE.
- DONE:
  - data_out and out_valid held stable while out_ready=0; L/R frozen.
  - round_idx=0.
  - On out_valid & out_ready: out_valid<=0, state<=IDLE.
- Latency: accept edge = edge 0; out_valid rises at edge ROUNDS. The earliest next accept is one cycle after the output handshake; no overlap between blocks.
- in_valid and decrypt are ignored outside IDLE; data_in changes during RUN have no effect.
- f_r_out = R register in all states; f_in is ignored outside RUN.
- Widths: XOR is bitwise 32-bit, no carries. cnt never exceeds ROUNDS; it wraps to 0 only via reset or return to IDLE, and cnt<=0 on the DONE->IDLE transition.
- busy = (state!=IDLE).

Test Plan:
- Swap check: ROUNDS=16, data_in=0x0123456789ABCDEF, decrypt=0, bench drives f_in=0 -> out_valid at edge 16, data_out=0x89ABCDEF01234567; round_idx sequence 1,2,...,16 during RUN.
- Decrypt order: same stimulus with decrypt=1 -> round_idx sequence 16,15,...,1; data_out=0x89ABCDEF01234567.
- Integration, with existing IP/expansion/S-box/P/key schedule/FP: key 0x133457799BBCDFF1, plaintext 0x0123456789ABCDEF -> ciphertext 0x85E813540F0AB405. Decrypt of 0x85E813540F0AB405 with the same key -> 0x0123456789ABCDEF.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid -> data_out and out_valid stable; in_ready=0; second in_valid pulse ignored.
  - Raise out_ready -> IDLE next cycle; the next block is accepted afterwards with correct result.
- Reset mid-operation: assert rst asynchronously at round 7 -> out_valid=0, round_idx=0, in_ready=1 immediately; no output for the aborted block. A new block after reset release completes normally at edge 16.
- ROUNDS=3 build: f_in=0xFFFFFFFF, data_in=0x0123456789ABCDEF -> after 3 rounds L3=0x76543210 (R0^F), R3=0x01234567; data_out=0x0123456776543210 at edge 3.
